// File: rtl/rpn_pkg.sv
// Shared types for the RPN evaluator: opcodes, error codes, FSM states.
// Build option: define RPN_MUL_EN to make opcode 8 (MUL) a legal binary op.
package rpn_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_DUP  = 4'd5,
    OP_DROP = 4'd6,
    OP_OUT  = 4'd7,
    OP_MUL  = 4'd8
  } opcode_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_OVERFLOW  = 2'd2,
    ERR_ILLEGAL   = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP_B,
    S_POP_A,
    S_PEEK,
    S_DROP,
    S_PUSH,
    S_EMIT,
    S_ERR
  } state_t;

  // Opcodes that pop two operands and push one result.
  function automatic logic is_binary_op(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: r = 1'b1;
`ifdef RPN_MUL_EN
      OP_MUL: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational binary-op datapath for the RPN engine; results wrap mod 2^W.
// Build option: RPN_MUL_EN adds the MUL branch (low W bits of a*b).
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OP_W-1:0] op,
  output logic [W-1:0]    result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
`ifdef RPN_MUL_EN
      OP_MUL:  result = a * b;
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_engine.sv
// RPN token evaluator driving the push/pop side of an external LIFO stack.
// Build option: RPN_MUL_EN enables opcode 8 (MUL); otherwise it is illegal.
module rpn_engine
  import rpn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic         tok_is_op,
  input  logic [W-1:0] tok_data,
  output logic         lifo_push,
  output logic         lifo_pop,
  output logic [W-1:0] lifo_din,
  input  logic [W-1:0] lifo_dout,
  input  logic         lifo_full,
  input  logic         lifo_empty,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic         err,
  output logic [1:0]   err_code
);

  state_t          state, state_n;
  err_code_t       ecode, ecode_n;
  logic [OP_W-1:0] op, op_n;
  logic [W-1:0]    val, val_n;
  logic [W-1:0]    res, res_n;
  logic [W-1:0]    b_opnd, b_opnd_n;
  logic [W-1:0]    alu_out;
  logic            ready_c, push_c, pop_c, emit_c;

  // A comes straight from the top of stack while in POP_A.
  rpn_alu #(.W(W)) u_alu (
    .a      (lifo_dout),
    .b      (b_opnd),
    .op     (op),
    .result (alu_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ecode <= ERR_NONE;
      op    <= '0;
      val   <= '0;
      res   <= '0;
    end else begin
      state <= state_n;
      ecode <= ecode_n;
      op    <= op_n;
      val   <= val_n;
      res   <= res_n;
    end
  end

  always_ff @(posedge clk) begin
    b_opnd <= b_opnd_n;
  end

  always_comb begin
    state_n  = state;
    ecode_n  = ecode;
    op_n     = op;
    val_n    = val;
    res_n    = res;
    b_opnd_n = b_opnd;
    ready_c  = 1'b0;
    push_c   = 1'b0;
    pop_c    = 1'b0;
    emit_c   = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready_c = 1'b1;
        if (tok_valid) begin
          if (!tok_is_op) begin
            val_n   = tok_data;
            state_n = S_PUSH;
          end else begin
            op_n = tok_data[OP_W-1:0];
            if (is_binary_op(tok_data[OP_W-1:0])) begin
              state_n = S_POP_B;
            end else if (tok_data[OP_W-1:0] == OP_DUP || tok_data[OP_W-1:0] == OP_OUT) begin
              state_n = S_PEEK;
            end else if (tok_data[OP_W-1:0] == OP_DROP) begin
              state_n = S_DROP;
            end else begin
              state_n = S_ERR;
              ecode_n = ERR_ILLEGAL;
            end
          end
        end
      end
      S_POP_B: begin
        if (lifo_empty) begin
          state_n = S_ERR;
          ecode_n = ERR_UNDERFLOW;
        end else begin
          b_opnd_n = lifo_dout;
          pop_c    = 1'b1;
          state_n  = S_POP_A;
        end
      end
      S_POP_A: begin
        if (lifo_empty) begin
          state_n = S_ERR;
          ecode_n = ERR_UNDERFLOW;
        end else begin
          val_n   = alu_out;
          pop_c   = 1'b1;
          state_n = S_PUSH;
        end
      end
      S_PEEK: begin
        if (lifo_empty) begin
          state_n = S_ERR;
          ecode_n = ERR_UNDERFLOW;
        end else if (op == OP_DUP) begin
          val_n   = lifo_dout;
          state_n = S_PUSH;
        end else begin
          res_n   = lifo_dout;
          state_n = S_EMIT;
        end
      end
      S_DROP: begin
        if (lifo_empty) begin
          state_n = S_ERR;
          ecode_n = ERR_UNDERFLOW;
        end else begin
          pop_c   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_PUSH: begin
        if (lifo_full) begin
          state_n = S_ERR;
          ecode_n = ERR_OVERFLOW;
        end else begin
          push_c  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_EMIT: begin
        emit_c  = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR: begin
        state_n = S_ERR;
      end
    endcase
  end

  // Strobes are masked during reset so an aborted operation issues nothing.
  assign tok_ready = ready_c & ~reset;
  assign lifo_push = push_c & ~reset;
  assign lifo_pop  = pop_c & ~reset;
  assign res_valid = emit_c & ~reset;
  assign lifo_din  = val;
  assign res_data  = res;
  assign err       = (state == S_ERR);
  assign err_code  = ecode;

endmodule

// File: tb/tb_rpn_engine.sv
// Self-checking bench for rpn_engine with a behavioural 8x8 LIFO attached.
// Honours RPN_MUL_EN for the expected MUL behaviour.
module tb_rpn_engine;

  localparam int W = 8;
`ifdef RPN_MUL_EN
  localparam bit HAS_MUL = 1'b1;
`else
  localparam bit HAS_MUL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic         tok_is_op = 1'b0;
  logic [W-1:0] tok_data = '0;
  logic         lifo_push, lifo_pop;
  logic [W-1:0] lifo_din, lifo_dout;
  logic         lifo_full, lifo_empty;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         err;
  logic [1:0]   err_code;

  int checks = 0;
  int failures = 0;
  int overlap = 0;
  logic [7:0] res_q[$];

  always #5 clk = ~clk;

  rpn_engine #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_is_op  (tok_is_op),
    .tok_data   (tok_data),
    .lifo_push  (lifo_push),
    .lifo_pop   (lifo_pop),
    .lifo_din   (lifo_din),
    .lifo_dout  (lifo_dout),
    .lifo_full  (lifo_full),
    .lifo_empty (lifo_empty),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .err        (err),
    .err_code   (err_code)
  );

  // Behavioural LIFO: combinational top/flags, push has priority over pop.
  logic [7:0] mem [0:7];
  logic [3:0] cnt = 4'd0;
  assign lifo_empty = (cnt == 4'd0);
  assign lifo_full  = (cnt == 4'd8);
  assign lifo_dout  = (cnt == 4'd0) ? 8'h00 : mem[3'(cnt - 4'd1)];

  always @(posedge clk) begin
    if (reset) cnt <= 4'd0;
    else if (lifo_push) begin
      if (cnt < 4'd8) begin
        mem[cnt[2:0]] <= lifo_din;
        cnt <= cnt + 4'd1;
      end
    end else if (lifo_pop && cnt > 4'd0) cnt <= cnt - 4'd1;
  end

  always @(negedge clk) begin
    if (res_valid) res_q.push_back(res_data);
    if (lifo_push && lifo_pop) overlap++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = '0;
    @(negedge clk);
    chk("rst_tok_ready", tok_ready, 0);
    chk("rst_strobes", {lifo_push, lifo_pop, res_valid}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    res_q.delete();
    @(negedge clk);
    chk("post_rst_ready", tok_ready, 1);
    chk("post_rst_err", {err, err_code}, 0);
    chk("post_rst_data", {lifo_din, res_data}, 0);
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic is_op, input logic [7:0] d);
    bit acc;
    acc = 1'b0;
    tok_valid = 1'b1; tok_is_op = is_op; tok_data = d;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = tok_ready;
      @(posedge clk); #1;
    end
    tok_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL tok_accept_timeout: got ready=0 expected ready=1");
    end
  endtask

  task automatic idle_wait();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = tok_ready;
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL idle_timeout: got ready=0 expected ready=1");
    end
  endtask

  // Drives one token and checks it is accepted this cycle (cycle N).
  task automatic issue(input string name, input logic is_op, input logic [7:0] d);
    tok_valid = 1'b1; tok_is_op = is_op; tok_data = d;
    @(negedge clk);
    chk(name, tok_ready, 1);
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  function automatic int model_alu(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      default: return (a * b) % 256;
    endcase
  endfunction

  typedef struct {
    int         n;
    logic [8:0] tk[4];
    int         nres;
    logic [7:0] res;
    logic [1:0] ecode;
    int         depth;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [8:0] tn(input int v); return {1'b0, 8'(v)}; endfunction
  function automatic logic [8:0] to(input int v); return {1'b1, 8'(v)}; endfunction

  task automatic add_vec(input int n, input logic [8:0] t0, input logic [8:0] t1,
                         input logic [8:0] t2, input logic [8:0] t3, input int nres,
                         input logic [7:0] res, input logic [1:0] ec, input int depth);
    vec_t v;
    v.n = n; v.tk[0] = t0; v.tk[1] = t1; v.tk[2] = t2; v.tk[3] = t3;
    v.nres = nres; v.res = res; v.ecode = ec; v.depth = depth;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int strobes, ready_hi;
    int stk[$];
    logic [7:0] expq[$];
    int mcode, v, a, b;
    bit is_op;

    // Directed programs: token list, expected OUT count/value, error code, final depth.
    add_vec(4, tn(5), tn(3), to(0), to(7), 1, 8'h08, 2'd0, 1);
    add_vec(4, tn(3), tn(5), to(1), to(7), 1, 8'hFE, 2'd0, 1);
    add_vec(4, tn(8'hF0), tn(8'h3C), to(4), to(7), 1, 8'hCC, 2'd0, 1);
    add_vec(4, tn(8'hC5), tn(8'h5A), to(2), to(7), 1, 8'h40, 2'd0, 1);
    add_vec(4, tn(8'h81), tn(8'h12), to(3), to(7), 1, 8'h93, 2'd0, 1);
    add_vec(4, tn(200), tn(100), to(0), to(7), 1, 8'd44, 2'd0, 1);
    add_vec(4, tn(4), to(5), to(0), to(7), 1, 8'h08, 2'd0, 1);
    add_vec(4, tn(9), tn(1), to(6), to(7), 1, 8'h09, 2'd0, 1);
    add_vec(2, tn(7), to(0), 0, 0, 0, 8'h00, 2'd1, 0);
    add_vec(1, to(6), 0, 0, 0, 0, 8'h00, 2'd1, 0);
    add_vec(1, to(7), 0, 0, 0, 0, 8'h00, 2'd1, 0);
    add_vec(1, to(5), 0, 0, 0, 0, 8'h00, 2'd1, 0);
    add_vec(1, to(9), 0, 0, 0, 0, 8'h00, 2'd3, 0);
    add_vec(1, to(15), 0, 0, 0, 0, 8'h00, 2'd3, 0);
    if (HAS_MUL) add_vec(4, tn(6), tn(7), to(8), to(7), 1, 8'd42, 2'd0, 1);
    else         add_vec(3, tn(6), tn(7), to(8), 0, 0, 8'h00, 2'd3, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      do_reset();
      for (int t = 0; t < vecs[i].n; t++) send(vecs[i].tk[t][8], vecs[i].tk[t][7:0]);
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_nres", i), res_q.size(), vecs[i].nres);
      if (vecs[i].nres > 0 && res_q.size() > 0) chk($sformatf("vec%0d_res", i), res_q[$], vecs[i].res);
      chk($sformatf("vec%0d_err", i), err, (vecs[i].ecode != 2'd0));
      chk($sformatf("vec%0d_code", i), err_code, vecs[i].ecode);
      if (vecs[i].ecode == 2'd0) chk($sformatf("vec%0d_depth", i), cnt, vecs[i].depth);
    end

    // Cycle-exact timing of each token class.
    do_reset();
    issue("opnd_accept", 1'b0, 8'h11);
    @(negedge clk);
    chk("opnd_push_n1", {lifo_push, lifo_pop, lifo_din}, {2'b10, 8'h11});
    chk("opnd_ready_n1", tok_ready, 0);
    @(negedge clk);
    chk("opnd_ready_n2", {tok_ready, lifo_push}, 2'b10);
    @(posedge clk); #1;
    send(1'b0, 8'h22);
    idle_wait();
    issue("add_accept", 1'b1, 8'h00);
    @(negedge clk); chk("add_pop_n1", {lifo_push, lifo_pop, tok_ready}, 3'b010);
    @(negedge clk); chk("add_pop_n2", {lifo_push, lifo_pop, tok_ready}, 3'b010);
    @(negedge clk); chk("add_push_n3", {lifo_push, lifo_pop, lifo_din}, {2'b10, 8'h33});
    @(negedge clk); chk("add_ready_n4", {tok_ready, lifo_push, lifo_pop}, 3'b100);
    @(posedge clk); #1;
    issue("out_accept", 1'b1, 8'h07);
    @(negedge clk); chk("out_n1", {res_valid, tok_ready}, 2'b00);
    @(negedge clk); chk("out_emit_n2", {res_valid, res_data}, {1'b1, 8'h33});
    @(negedge clk); chk("out_ready_n3", {tok_ready, res_valid}, 2'b10);
    @(posedge clk); #1;
    issue("dup_accept", 1'b1, 8'h05);
    @(negedge clk); chk("dup_n1", {lifo_push, tok_ready}, 2'b00);
    @(negedge clk); chk("dup_push_n2", {lifo_push, lifo_din}, {1'b1, 8'h33});
    @(negedge clk); chk("dup_ready_n3", tok_ready, 1);
    @(posedge clk); #1;
    issue("drop_accept", 1'b1, 8'h06);
    @(negedge clk); chk("drop_pop_n1", {lifo_pop, tok_ready}, 2'b10);
    @(negedge clk); chk("drop_ready_n2", {tok_ready, lifo_pop}, 2'b10);
    chk("drop_depth", cnt, 1);

    // Overflow: the ninth operand finds the stack full.
    do_reset();
    for (int k = 0; k < 9; k++) send(1'b0, 8'(k + 1));
    @(negedge clk);
    @(negedge clk);
    chk("ovf_err", {err, err_code}, 3'b110);
    chk("ovf_depth", cnt, 8);
    ready_hi = 0;
    tok_valid = 1'b1; tok_is_op = 1'b0; tok_data = 8'h55;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (tok_ready) ready_hi++;
    end
    tok_valid = 1'b0;
    chk("ovf_ready_stuck", ready_hi, 0);
    chk("ovf_err_sticky", {err, err_code}, 3'b110);

    // Reset during POP_A aborts without strobes.
    do_reset();
    send(1'b0, 8'h01);
    idle_wait();
    send(1'b0, 8'h02);
    idle_wait();
    issue("abort_accept", 1'b1, 8'h00);
    @(negedge clk); chk("abort_popb", lifo_pop, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); chk("abort_no_strobe", {lifo_push, lifo_pop, res_valid}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); chk("abort_idle", {tok_ready, err}, 2'b10);
    strobes = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (lifo_push || lifo_pop || res_valid) strobes++;
    end
    chk("abort_quiet", strobes, 0);
    chk("abort_err_code", err_code, 0);

    // Random token streams against a queue-based stack model.
    for (int run = 0; run < 30; run++) begin
      stk.delete();
      expq.delete();
      mcode = 0;
      do_reset();
      for (int t = 0; t < 24 && mcode == 0; t++) begin
        if (stk.size() == 0) is_op = ($urandom_range(0, 9) == 0);
        else is_op = ($urandom_range(0, 99) >= ((run % 3 == 0) ? 80 : 45));
        if (!is_op) begin
          v = $urandom_range(0, 255);
          if (stk.size() == 8) mcode = 2;
          else stk.push_back(v);
        end else begin
          if ($urandom_range(0, 49) == 0) v = $urandom_range(9, 15);
          else v = $urandom_range(0, HAS_MUL ? 8 : 7);
          if (v <= 4 || (v == 8 && HAS_MUL)) begin
            if (stk.size() == 0) mcode = 1;
            else begin
              b = stk.pop_back();
              if (stk.size() == 0) mcode = 1;
              else begin
                a = stk.pop_back();
                stk.push_back(model_alu(v, a, b));
              end
            end
          end else if (v == 5) begin
            if (stk.size() == 0) mcode = 1;
            else if (stk.size() == 8) mcode = 2;
            else stk.push_back(stk[$]);
          end else if (v == 6) begin
            if (stk.size() == 0) mcode = 1;
            else void'(stk.pop_back());
          end else if (v == 7) begin
            if (stk.size() == 0) mcode = 1;
            else expq.push_back(8'(stk[$]));
          end else mcode = 3;
        end
        send(is_op, 8'(v));
      end
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk($sformatf("rnd%0d_nres", run), res_q.size(), expq.size());
      for (int k = 0; k < expq.size() && k < res_q.size(); k++)
        chk($sformatf("rnd%0d_res%0d", run, k), res_q[k], expq[k]);
      chk($sformatf("rnd%0d_code", run), {err, err_code}, {(mcode != 0), 2'(mcode)});
      if (mcode == 0) begin
        chk($sformatf("rnd%0d_depth", run), cnt, stk.size());
        for (int k = 0; k < stk.size() && k < int'(cnt); k++)
          chk($sformatf("rnd%0d_stk%0d", run, k), mem[k], stk[k]);
      end
    end

    chk("push_pop_exclusive", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
